// File: rtl/teclado_emisor.sv
// -----------------------------------------------------------------------------
// teclado_emisor
// Transmitting end of the cashier's digit interface. Scans a 4x4 matrix
// keypad, debounces each press and release, and turns every accepted key into
// a single strobe: numeric keys give a digito/digito_stb transfer, non-digit
// keys give a tecla_invalida pulse. A held key never repeats.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous reset, active low
//   filas[3:0]     row sense, bit i = row i, high = key closed in driven column
//   habilitar      1 = strobes allowed, 0 = keep scanning but stay silent
//   columnas[3:0]  one-hot column drive, bit j = column j, active high
//   digito[3:0]    BCD value of the last accepted digit, holds between strobes
//   digito_stb     one-cycle pulse, digito valid in the same cycle
//   tecla_invalida one-cycle pulse when a non-digit key is accepted
// -----------------------------------------------------------------------------
module teclado_emisor #(
   parameter int unsigned SCAN_CYCLES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] filas,
   input  logic       habilitar,
   output logic [3:0] columnas,
   output logic [3:0] digito,
   output logic       digito_stb,
   output logic       tecla_invalida
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   typedef enum logic [1:0] {
      ESCANEO,
      REBOTE,
      EMITIR,
      ESPERA_SOLTAR
   } estado_t;

   estado_t          estado;
   logic [CNT_W-1:0] cnt_dwell;
   logic [CNT_W-1:0] cnt_rebote;
   logic [3:0]       fila_lat;

   logic [CNT_W-1:0] rebote_inc;
   logic [4:0]       tecla;

   // Saturating increment for the 8-bit counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      r = (v == CNT_MAX) ? v : v + CNT_W'(1);
      return r;
   endfunction

   // True when exactly one row line is active.
   function automatic logic una_fila(input logic [3:0] v);
      logic r;
      r = (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
      return r;
   endfunction

   // Index of a one-hot nibble.
   function automatic logic [1:0] indice(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      case (v)
         4'b0001: r = 2'd0;
         4'b0010: r = 2'd1;
         4'b0100: r = 2'd2;
         default: r = 2'd3;
      endcase
      return r;
   endfunction

   // Key map lookup: returns {is_digit, bcd_value}.
   function automatic logic [4:0] decodificar(input logic [3:0] fila,
                                              input logic [3:0] col);
      logic [4:0] r;
      r = 5'b0_0000;
      case ({indice(fila), indice(col)})
         4'd0:    r = {1'b1, 4'd1};
         4'd1:    r = {1'b1, 4'd2};
         4'd2:    r = {1'b1, 4'd3};
         4'd4:    r = {1'b1, 4'd4};
         4'd5:    r = {1'b1, 4'd5};
         4'd6:    r = {1'b1, 4'd6};
         4'd8:    r = {1'b1, 4'd7};
         4'd9:    r = {1'b1, 4'd8};
         4'd10:   r = {1'b1, 4'd9};
         4'd13:   r = {1'b1, 4'd0};
         default: r = 5'b0_0000;
      endcase
      return r;
   endfunction

   // Next column in the 0001 -> 0010 -> 0100 -> 1000 -> 0001 ring.
   function automatic logic [3:0] rotar(input logic [3:0] v);
      logic [3:0] r;
      r = {v[2:0], v[3]};
      return r;
   endfunction

   assign rebote_inc = sat_inc(cnt_rebote);
   // columnas is frozen while a key is tracked, so it doubles as the latched column.
   assign tecla      = decodificar(fila_lat, columnas);

   // Scan / debounce / emit / release-wait controller with registered outputs.
   // The pulses are registered on the edge that enters EMITIR, so they are high
   // exactly during the EMITIR cycle (press seen at t -> strobe at t+D+1).
   always_ff @(posedge clk) begin
      if (!reset) begin
         estado         <= ESCANEO;
         columnas       <= 4'b0001;
         digito         <= 4'd0;
         digito_stb     <= 1'b0;
         tecla_invalida <= 1'b0;
         cnt_dwell      <= '0;
         cnt_rebote     <= '0;
         fila_lat       <= 4'd0;
      end else begin
         digito_stb     <= 1'b0;
         tecla_invalida <= 1'b0;

         case (estado)
            ESCANEO: begin
               if (una_fila(filas)) begin
                  // Lock onto this key; multi-key patterns fall through to scanning.
                  fila_lat   <= filas;
                  cnt_rebote <= '0;
                  cnt_dwell  <= '0;
                  estado     <= REBOTE;
               end else if (cnt_dwell >= DWELL_LAST) begin
                  cnt_dwell <= '0;
                  columnas  <= rotar(columnas);
               end else begin
                  cnt_dwell <= sat_inc(cnt_dwell);
               end
            end

            REBOTE: begin
               if (filas == fila_lat) begin
                  cnt_rebote <= rebote_inc;
                  if (rebote_inc == DEB_TARGET) begin
                     estado <= EMITIR;
                     if (habilitar) begin
                        if (tecla[4]) begin
                           digito_stb <= 1'b1;
                           digito     <= tecla[3:0];
                        end else begin
                           tecla_invalida <= 1'b1;
                        end
                     end
                  end
               end else begin
                  // Bounce: abandon this key and resume on the following column.
                  estado     <= ESCANEO;
                  columnas   <= rotar(columnas);
                  cnt_dwell  <= '0;
                  cnt_rebote <= '0;
               end
            end

            EMITIR: begin
               cnt_rebote <= '0;
               estado     <= ESPERA_SOLTAR;
            end

            ESPERA_SOLTAR: begin
               // Release must be seen as DEBOUNCE_CYCLES consecutive idle samples.
               if (filas == 4'd0) begin
                  if (rebote_inc == DEB_TARGET) begin
                     estado     <= ESCANEO;
                     columnas   <= rotar(columnas);
                     cnt_dwell  <= '0;
                     cnt_rebote <= '0;
                  end else begin
                     cnt_rebote <= rebote_inc;
                  end
               end else begin
                  cnt_rebote <= '0;
               end
            end

            default: begin
               estado <= ESCANEO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_teclado_emisor.sv
// -----------------------------------------------------------------------------
// tb_teclado_emisor
// Bench for teclado_emisor: a physical keypad model drives filas from the
// pressed-key matrix and the driven column; a behavioural model predicts the
// outputs every cycle; directed scenarios pin literal expectations, followed by
// a randomized press/bounce/reset phase.
// -----------------------------------------------------------------------------
module tb_teclado_emisor;

   localparam int unsigned SCAN = 2;
   localparam int unsigned DEB  = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] filas;
   logic       habilitar;
   logic [3:0] columnas;
   logic [3:0] digito;
   logic       digito_stb;
   logic       tecla_invalida;

   teclado_emisor #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk            (clk),
      .reset          (reset),
      .filas          (filas),
      .habilitar      (habilitar),
      .columnas       (columnas),
      .digito         (digito),
      .digito_stb     (digito_stb),
      .tecla_invalida (tecla_invalida)
   );

   always #5 clk = ~clk;

   // Key values indexed by row*4+col; -1 marks A-D, * and #.
   int KEYVAL [16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, -1, 0, -1, -1};

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Keypad stimulus
   logic [15:0] pressed = '0;
   bit          ovr_en  = 1'b0;
   logic [3:0]  ovr_val = 4'd0;

   // Observation window
   int w_stb = 0, w_inv = 0, w_first_stb = -1, first_nz = -1;
   int last_stb = -1000;
   bit prev_stb = 1'b0, prev_inv = 1'b0;

   // Behavioural model state: scan position, tracked key and its history.
   int         m_col = 0, m_dwell = 0;
   bit         m_locked = 1'b0, m_fired = 1'b0, m_skip = 1'b0;
   int         m_row = 0, m_good = 0, m_quiet = 0;
   logic [3:0] m_dig = 4'd0;
   bit         m_stb = 1'b0, m_inv = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] keypad(input logic [15:0] p, input logic [3:0] cols);
      logic [3:0] f;
      f = 4'd0;
      for (int r = 0; r < 4; r++) f[r] = |(p[r*4 +: 4] & cols);
      return f;
   endfunction

   // Advance the model by one clock edge with the inputs seen in that cycle.
   task automatic model_step(input logic rst, input logic [3:0] f, input logic en);
      int v;
      m_stb = 1'b0;
      m_inv = 1'b0;
      if (!rst) begin
         m_col = 0; m_dwell = 0; m_locked = 1'b0; m_dig = 4'd0;
         return;
      end
      if (!m_locked) begin
         if ($countones(f) == 1) begin
            m_locked = 1'b1; m_fired = 1'b0; m_skip = 1'b0;
            m_good = 0; m_quiet = 0;
            for (int r = 0; r < 4; r++) if (f[r]) m_row = r;
         end else begin
            m_dwell++;
            if (m_dwell >= SCAN) begin m_dwell = 0; m_col = (m_col + 1) % 4; end
         end
      end else if (!m_fired) begin
         if (f == (4'b0001 << m_row)) begin
            m_good++;
            if (m_good == DEB) begin
               m_fired = 1'b1; m_skip = 1'b1;
               if (en) begin
                  v = KEYVAL[m_row*4 + m_col];
                  if (v >= 0) begin m_stb = 1'b1; m_dig = 4'(v); end
                  else m_inv = 1'b1;
               end
            end
         end else begin
            m_locked = 1'b0; m_col = (m_col + 1) % 4; m_dwell = 0;
         end
      end else if (m_skip) begin
         m_skip = 1'b0;
      end else begin
         if (f == 4'd0) m_quiet++; else m_quiet = 0;
         if (m_quiet == DEB) begin
            m_locked = 1'b0; m_col = (m_col + 1) % 4; m_dwell = 0;
         end
      end
   endtask

   task automatic compare();
      chk("columnas", columnas, 1 << m_col);
      chk("digito", digito, m_dig);
      chk("digito_stb", digito_stb, m_stb);
      chk("tecla_invalida", tecla_invalida, m_inv);
      chk("stb_inv_exclusive", digito_stb & tecla_invalida, 0);
      if (prev_stb) chk("stb_width", digito_stb, 0);
      if (prev_inv) chk("inv_width", tecla_invalida, 0);
      if (digito_stb) begin
         w_stb++;
         if (w_first_stb < 0) w_first_stb = cyc;
         chk("stb_spacing", int'(cyc - last_stb >= 2*DEB + 2), 1);
         last_stb = cyc;
      end
      if (tecla_invalida) w_inv++;
      prev_stb = digito_stb;
      prev_inv = tecla_invalida;
   endtask

   // One clock: drive inputs, advance model on the edge, compare #1 later.
   // Outputs compared in step n belong to clock cycle n+1.
   task automatic step();
      logic [3:0] f;
      f = ovr_en ? ovr_val : keypad(pressed, columnas);
      filas = f;
      cyc++;
      if (f != 4'd0 && first_nz < 0) first_nz = cyc;
      @(posedge clk);
      model_step(reset, f, habilitar);
      if (!reset) last_stb = -1000;
      #1;
      compare();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic clear_win();
      w_stb = 0; w_inv = 0; w_first_stb = -1; first_nz = -1;
   endtask

   task automatic press(input int idx, input int hold, input int rel);
      pressed = '0;
      pressed[idx] = 1'b1;
      run(hold);
      pressed = '0;
      run(rel);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [3:0] seq [8];
      int kidx [4];
      int n;
      int bounce_end;

      seq  = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
      kidx = '{0, 1, 2, 4};

      reset = 1'b0; habilitar = 1'b1; filas = 4'd0;

      // Reset and scan ring
      run(3);
      chk("reset_columnas", columnas, 4'b0001);
      chk("reset_digito", digito, 0);
      chk("reset_stb", digito_stb, 0);
      chk("reset_inv", tecla_invalida, 0);
      reset = 1'b1;
      clear_win();
      for (int i = 0; i < 8; i++) begin
         step();
         chk("scan_seq", columnas, seq[i]);
      end
      chk("scan_no_stb", w_stb, 0);
      chk("scan_no_inv", w_inv, 0);

      // Key 5 held 20 cycles
      clear_win();
      press(5, 20, 15);
      chk("k5_count", w_stb, 1);
      chk("k5_latency", (w_first_stb + 1) - first_nz, 5);
      chk("k5_digito", digito, 5);

      // Bounce then stable key 5
      n = 0;
      while (columnas != 4'b0010 && n < 20) begin step(); n++; end
      chk("bounce_align", columnas, 4'b0010);
      clear_win();
      ovr_en = 1'b1; ovr_val = 4'b0010; run(2);
      ovr_val = 4'b0000; run(1);
      ovr_en = 1'b0;
      bounce_end = cyc;
      press(5, 30, 15);
      chk("bounce_count", w_stb, 1);
      chk("bounce_after_stable", int'(w_first_stb > bounce_end), 1);
      chk("bounce_digito", digito, 5);

      // Keys 1,2,3,4
      for (int i = 0; i < 4; i++) begin
         clear_win();
         press(kidx[i], 25, 15);
         chk("seq_count", w_stb, 1);
         chk("seq_digito", digito, i + 1);
      end
      run(10);
      chk("seq_hold", digito, 4);

      // '#' then '0'
      clear_win();
      press(14, 25, 15);
      chk("hash_inv", w_inv, 1);
      chk("hash_no_stb", w_stb, 0);
      chk("hash_digito", digito, 4);
      clear_win();
      press(13, 25, 15);
      chk("zero_count", w_stb, 1);
      chk("zero_digito", digito, 0);

      // habilitar low during '7'
      habilitar = 1'b0;
      clear_win();
      press(8, 25, 15);
      habilitar = 1'b1;
      chk("dis_stb", w_stb, 0);
      chk("dis_inv", w_inv, 0);
      chk("dis_digito", digito, 0);

      // Reset while debouncing
      clear_win();
      pressed = '0; pressed[5] = 1'b1;
      n = 0;
      while (!m_locked && n < 30) begin step(); n++; end
      chk("rebote_lock_seen", int'(m_locked), 1);
      run(2);
      pressed = '0;
      reset = 1'b0;
      step();
      chk("rebote_reset_cols", columnas, 4'b0001);
      chk("rebote_reset_stb", digito_stb, 0);
      reset = 1'b1;
      run(20);
      chk("rebote_no_stb", w_stb, 0);

      // Two rows at once in column 0
      clear_win();
      pressed = 16'h0011;
      run(30);
      pressed = '0;
      run(10);
      chk("multi_no_stb", w_stb, 0);
      chk("multi_no_inv", w_inv, 0);

      // Randomized presses, bounces, resets and enable changes
      for (int it = 0; it < 200; it++) begin
         if (!m_locked && $urandom_range(0, 7) == 0) habilitar = ~habilitar;
         if ($urandom_range(0, 19) == 0) begin
            reset = 1'b0; step(); reset = 1'b1;
         end
         pressed = '0;
         pressed[$urandom_range(0, 15)] = 1'b1;
         if ($urandom_range(0, 7) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
         if ($urandom_range(0, 2) == 0) begin
            ovr_en = 1'b1;
            repeat ($urandom_range(1, 3)) begin
               ovr_val = 4'($urandom);
               step();
            end
            ovr_en = 1'b0;
         end
         run($urandom_range(0, 30));
         pressed = '0;
         run($urandom_range(0, 20));
      end

      habilitar = 1'b1;
      pressed = '0;
      run(30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
